// File: rtl/mips_mem_stage.sv
// mips_mem_stage: MEM stage of the 5-stage MIPS pipeline (data memory, pass-throughs, branch decision)
//   clk, rst_n                  : clock, async active-low reset (clears the whole memory)
//   ALUResult                   : byte address for load/store, also forwarded as ALUResult_out
//   WriteData                   : store data, written on the rising edge when MemWrite=1
//   WriteReg, WBControl         : forwarded unchanged as WriteReg_out, WBControl_out
//   MemWrite, MemRead           : store enable, load enable (ReadData is 0 when MemRead=0)
//   Branch, Zero                : PCSrc = Branch & Zero
//   ReadData                    : combinational load data
module mips_mem_stage #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        WriteReg,
    input  logic [1:0]        WBControl,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              Branch,
    input  logic              Zero,
    output logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] ALUResult_out,
    output logic [4:0]        WriteReg_out,
    output logic [1:0]        WBControl_out,
    output logic              PCSrc
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    // byte offset dropped and upper bits ignored: misaligned accesses align down, addresses wrap
    assign idx = ALUResult[ADDR_BITS+1:2];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (MemWrite)
            mem[idx] <= WriteData;
    assign ReadData      = MemRead ? mem[idx] : '0;
    assign ALUResult_out = ALUResult;
    assign WriteReg_out  = WriteReg;
    assign WBControl_out = WBControl;
    assign PCSrc         = Branch & Zero;
endmodule

// File: tb/tb_mips_mem_stage.sv
// tb_mips_mem_stage: directed self-checking bench for mips_mem_stage
module tb_mips_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  WriteReg = '0;
    logic [1:0]  WBControl = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] ReadData;
    logic [31:0] ALUResult_out;
    logic [4:0]  WriteReg_out;
    logic [1:0]  WBControl_out;
    logic        PCSrc;
    int          n_cmp = 0;
    int          n_bad = 0;

    mips_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ALUResult(ALUResult), .WriteData(WriteData),
        .WriteReg(WriteReg), .WBControl(WBControl), .MemWrite(MemWrite), .MemRead(MemRead),
        .Branch(Branch), .Zero(Zero), .ReadData(ReadData), .ALUResult_out(ALUResult_out),
        .WriteReg_out(WriteReg_out), .WBControl_out(WBControl_out), .PCSrc(PCSrc)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        ALUResult = 32'h4; WriteReg = 5'd2; WBControl = 2'b01;
        MemRead = 1'b1; MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL reset_read got %h want 00000000", ReadData); end
        n_cmp++; if (ALUResult_out !== 32'h4) begin n_bad++; $display("FAIL reset_alu_out got %h want 00000004", ALUResult_out); end
        n_cmp++; if (WriteReg_out !== 5'd2) begin n_bad++; $display("FAIL reset_wreg_out got %h want 02", WriteReg_out); end
        n_cmp++; if (WBControl_out !== 2'b01) begin n_bad++; $display("FAIL reset_wbc_out got %b want 01", WBControl_out); end
        n_cmp++; if (PCSrc !== 1'b0) begin n_bad++; $display("FAIL reset_pcsrc got %b want 0", PCSrc); end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        ALUResult = 32'h4; WriteData = 32'h12345678; MemWrite = 1'b1; MemRead = 1'b0;
        WriteReg = 5'd9; WBControl = 2'b10;
        #1;
        n_cmp++; if (WriteReg_out !== 5'd9) begin n_bad++; $display("FAIL pass_wreg got %h want 09", WriteReg_out); end
        n_cmp++; if (WBControl_out !== 2'b10) begin n_bad++; $display("FAIL pass_wbc got %b want 10", WBControl_out); end
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1;
        #1;
        n_cmp++; if (ReadData !== 32'h12345678) begin n_bad++; $display("FAIL readback got %h want 12345678", ReadData); end
        ALUResult = 32'h8;
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL other_word got %h want 00000000", ReadData); end
        n_cmp++; if (ALUResult_out !== 32'h8) begin n_bad++; $display("FAIL pass_alu got %h want 00000008", ALUResult_out); end
    endtask

    task automatic test_align_wrap;
        logic [31:0] addrs [3];
        addrs = '{32'h5, 32'h7, 32'h404};
        MemRead = 1'b1; MemWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ALUResult = addrs[i];
            #1;
            n_cmp++;
            if (ReadData !== 32'h12345678) begin
                n_bad++; $display("FAIL align_wrap addr %h got %h want 12345678", addrs[i], ReadData);
            end
        end
    endtask

    task automatic test_read_gate_rw;
        @(negedge clk);
        ALUResult = 32'h4; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL read_gate got %h want 00000000", ReadData); end
        MemRead = 1'b1; MemWrite = 1'b1; WriteData = 32'hCAFEF00D;
        #1;
        n_cmp++; if (ReadData !== 32'h12345678) begin n_bad++; $display("FAIL rw_before got %h want 12345678", ReadData); end
        @(posedge clk);
        #1;
        n_cmp++; if (ReadData !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rw_after got %h want cafef00d", ReadData); end
        @(negedge clk);
        MemWrite = 1'b0;
        ALUResult = 32'h20; WriteData = 32'h0BADBEEF; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        n_cmp++; if (ReadData !== 32'h0BADBEEF) begin n_bad++; $display("FAIL second_word got %h want 0badbeef", ReadData); end
        ALUResult = 32'h4;
        #1;
        n_cmp++; if (ReadData !== 32'hCAFEF00D) begin n_bad++; $display("FAIL first_kept got %h want cafef00d", ReadData); end
    endtask

    task automatic test_branch;
        logic [3:0] want;
        want = 4'b1000;
        MemRead = 1'b0; MemWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {Branch, Zero} = 2'(i);
            #1;
            n_cmp++;
            if (PCSrc !== want[i]) begin
                n_bad++; $display("FAIL branch bz=%b got %b want %b", 2'(i), PCSrc, want[i]);
            end
        end
        MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        ALUResult = 32'h4; WriteData = 32'hDEADBEEF; MemWrite = 1'b1; MemRead = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL async_clear got %h want 00000000", ReadData); end
        Branch = 1'b1; Zero = 1'b1; WriteReg = 5'd31;
        #1;
        n_cmp++; if (PCSrc !== 1'b1) begin n_bad++; $display("FAIL reset_pcsrc_live got %b want 1", PCSrc); end
        n_cmp++; if (WriteReg_out !== 5'd31) begin n_bad++; $display("FAIL reset_wreg_live got %h want 1f", WriteReg_out); end
        @(posedge clk);
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL write_in_reset got %h want 00000000", ReadData); end
        @(negedge clk);
        MemWrite = 1'b0; Branch = 1'b0; Zero = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL after_release got %h want 00000000", ReadData); end
        ALUResult = 32'h20;
        #1;
        n_cmp++; if (ReadData !== 32'h0) begin n_bad++; $display("FAIL after_release_20 got %h want 00000000", ReadData); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_align_wrap;
        test_read_gate_rw;
        test_branch;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
